// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
// Optional feature macro: MORSE_SEQ_LETTER_GAP_EN (adds the GAP state).
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MARK   = 3'd1,
    SPACE  = 3'd2,
`ifdef MORSE_SEQ_LETTER_GAP_EN
    GAP    = 3'd3,
`endif
    FINISH = 3'd4
  } morse_state_t;

  localparam logic [1:0] DOT_UNITS   = 2'd1;
  localparam logic [1:0] DASH_UNITS  = 2'd3;
  localparam logic [1:0] SPACE_UNITS = 2'd1;
  localparam logic [1:0] GAP_UNITS   = 2'd3;
  localparam int         MAX_LEN_DEFAULT = 5;

endpackage

// File: rtl/morse_sequencer_if.sv
// Letter request / status bundle between the encoder and the sequencer.
interface morse_sequencer_if #(
  parameter int MAX_LEN = 5
);
  logic               START;
  logic [MAX_LEN-1:0] PATTERN;
  logic [2:0]         LENGTH;
  logic               ABORT;
  logic               LED_OUT;
  logic               BUSY;
  logic               DONE;

  modport master (
    output START, PATTERN, LENGTH, ABORT,
    input  LED_OUT, BUSY, DONE
  );

  modport slave (
    input  START, PATTERN, LENGTH, ABORT,
    output LED_OUT, BUSY, DONE
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Free-running unit timer: wraps every UNIT_TICKS cycles, held at 0 by CLEAR.
module morse_unit_timer #(
  parameter int UNIT_TICKS = 25_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic CLEAR,
  output logic TICK
);

  localparam int CNT_W = $clog2(UNIT_TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  assign TICK = (cnt == LAST);

  // Count cycles within a unit; the wrap coincides with the tick.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (CLEAR || TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Plays one Morse letter (dot/dash pattern, LSB first) on LED_OUT.
// Optional feature macro: MORSE_SEQ_LETTER_GAP_EN adds a 3-unit dark gap
// after the final mark, before DONE.
//
// state  | meaning
// IDLE   | waiting for a legal START; unit timer held at 0
// MARK   | LED on for 1 (dot) or 3 (dash) units
// SPACE  | LED off for 1 unit between symbols
// GAP    | LED off for 3 units after the last mark (macro only)
// FINISH | one-cycle DONE pulse, then IDLE
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_TICKS = 25_000_000,
  parameter int MAX_LEN    = MAX_LEN_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  morse_sequencer_if.slave  bus
);

  localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

  morse_state_t       state;
  logic [MAX_LEN-1:0] pat_q;
  logic [2:0]         len_q;
  logic [2:0]         idx;
  logic [1:0]         unit_cnt;
  logic               led_q;
  logic               busy_q;
  logic               done_q;
  logic               tick;
  logic               len_ok;
  logic [1:0]         mark_units;

  assign len_ok     = (bus.LENGTH != 3'd0) && (bus.LENGTH <= MAX_LEN_L);
  assign mark_units = pat_q[idx] ? DASH_UNITS : DOT_UNITS;

  assign bus.LED_OUT = led_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

  morse_unit_timer #(.UNIT_TICKS(UNIT_TICKS)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .CLEAR    (state == IDLE),
    .TICK     (tick)
  );

  // Sequencer FSM with registered LED/BUSY/DONE and the unit-multiple counter.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      unit_cnt <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && bus.ABORT) begin
        state    <= IDLE;
        idx      <= '0;
        unit_cnt <= '0;
        led_q    <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.START && !bus.ABORT && len_ok) begin
              pat_q    <= bus.PATTERN;
              len_q    <= bus.LENGTH;
              idx      <= '0;
              unit_cnt <= '0;
              state    <= MARK;
              led_q    <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          MARK: begin
            if (tick) begin
              if (unit_cnt == mark_units - 2'd1) begin
                unit_cnt <= '0;
                led_q    <= 1'b0;
                if ((idx + 3'd1) < len_q) begin
                  state <= SPACE;
                end else begin
`ifdef MORSE_SEQ_LETTER_GAP_EN
                  state <= GAP;
`else
                  state  <= FINISH;
                  done_q <= 1'b1;
`endif
                end
              end else begin
                unit_cnt <= unit_cnt + 2'd1;
              end
            end
          end
          SPACE: begin
            if (tick) begin
              if (unit_cnt == SPACE_UNITS - 2'd1) begin
                unit_cnt <= '0;
                idx      <= idx + 3'd1;
                state    <= MARK;
                led_q    <= 1'b1;
              end else begin
                unit_cnt <= unit_cnt + 2'd1;
              end
            end
          end
`ifdef MORSE_SEQ_LETTER_GAP_EN
          GAP: begin
            if (tick) begin
              if (unit_cnt == GAP_UNITS - 2'd1) begin
                unit_cnt <= '0;
                state    <= FINISH;
                done_q   <= 1'b1;
              end else begin
                unit_cnt <= unit_cnt + 2'd1;
              end
            end
          end
`endif
          FINISH: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer with UNIT_TICKS=4.
// Monitor turns LED_OUT/DONE activity into run-length events and checks
// them against hand-written expectations queued by the stimulus.
module tb_morse_sequencer;

  localparam int UT = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  morse_sequencer_if #(.MAX_LEN(5)) bus ();

  morse_sequencer #(.UNIT_TICKS(UT), .MAX_LEN(5)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int done_cnt = 0;

  // event code = kind*1000 + length; kind 1 = high run, 2 = low run, 3 = DONE
  function automatic int ev_h(int n); return 1000 + n; endfunction
  function automatic int ev_l(int n); return 2000 + n; endfunction
  function automatic int ev_d();      return 3000;     endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic emit(int code);
    int e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: unexpected event %0d, queue empty", code);
    end else begin
      e = exp_q.pop_front();
      if (e != code) begin
        bad++;
        $display("FAIL scoreboard: got event %0d expected %0d", code, e);
      end
    end
  endtask

  // Monitor: sample away from the active edge and report completed runs.
  bit prev_led = 1'b0;
  int hi = 0;
  int lo = 0;
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      prev_led = 1'b0;
      hi = 0;
      lo = 0;
    end else begin
      if (prev_led && !bus.LED_OUT) begin
        emit(ev_h(hi));
        hi = 0;
      end
      if (!prev_led && bus.LED_OUT && lo > 0) begin
        emit(ev_l(lo));
        lo = 0;
      end
      if (bus.LED_OUT) hi++;
      else if (bus.BUSY && !bus.DONE) lo++;
      if (bus.DONE) begin
        if (lo > 0) emit(ev_l(lo));
        lo = 0;
        emit(ev_d());
        done_cnt++;
      end
      if (!bus.BUSY && !bus.DONE) lo = 0;
      prev_led = bus.LED_OUT;
    end
  end

  task automatic start_letter(logic [4:0] pat, logic [2:0] len);
    @(negedge CLOCK_50);
    bus.START = 1'b1; bus.PATTERN = pat; bus.LENGTH = len;
    @(negedge CLOCK_50);
    bus.START = 1'b0;
  endtask

  // Returns at the negedge where DONE is seen, bounded by a cycle budget.
  task automatic wait_done(string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (bus.DONE) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  task automatic push_letter_a();
    exp_q.push_back(ev_h(4));
    exp_q.push_back(ev_l(4));
    exp_q.push_back(ev_h(12));
`ifdef MORSE_SEQ_LETTER_GAP_EN
    exp_q.push_back(ev_l(12));
`endif
    exp_q.push_back(ev_d());
  endtask

  int d0;

  initial begin
    bus.START = 1'b0; bus.PATTERN = '0; bus.LENGTH = '0; bus.ABORT = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check("reset_led",  int'(bus.LED_OUT), 0);
    check("reset_busy", int'(bus.BUSY), 0);
    check("reset_done", int'(bus.DONE), 0);

    // Letter A
    push_letter_a();
    start_letter(5'b00010, 3'd2);
    check("a_busy_on", int'(bus.BUSY), 1);
    wait_done("a_done");
    @(negedge CLOCK_50);
    check("a_busy_after_done", int'(bus.BUSY), 0);

    // Letter O
    exp_q.push_back(ev_h(12));
    exp_q.push_back(ev_l(4));
    exp_q.push_back(ev_h(12));
    exp_q.push_back(ev_l(4));
    exp_q.push_back(ev_h(12));
`ifdef MORSE_SEQ_LETTER_GAP_EN
    exp_q.push_back(ev_l(12));
`endif
    exp_q.push_back(ev_d());
    start_letter(5'b00111, 3'd3);
    wait_done("o_done");
    @(negedge CLOCK_50);
    check("o_busy_after_done", int'(bus.BUSY), 0);

    // Illegal lengths are ignored
    start_letter(5'b00001, 3'd0);
    check("len0_busy", int'(bus.BUSY), 0);
    start_letter(5'b00001, 3'd6);
    check("len6_busy", int'(bus.BUSY), 0);
    check("len6_led",  int'(bus.LED_OUT), 0);

    // START during playback does not disturb the letter in flight
    push_letter_a();
    start_letter(5'b00010, 3'd2);
    repeat (5) @(negedge CLOCK_50);
    bus.START = 1'b1; bus.PATTERN = 5'b00111; bus.LENGTH = 3'd3;
    @(negedge CLOCK_50);
    bus.START = 1'b0;
    wait_done("restart_done");
    @(negedge CLOCK_50);

    // ABORT during the second mark
    d0 = done_cnt;
    exp_q.push_back(ev_h(4));
    exp_q.push_back(ev_l(4));
    exp_q.push_back(ev_h(3));
    start_letter(5'b00010, 3'd2);
    repeat (10) @(negedge CLOCK_50);
    bus.ABORT = 1'b1;
    @(negedge CLOCK_50);
    bus.ABORT = 1'b0;
    check("abort_led",  int'(bus.LED_OUT), 0);
    check("abort_busy", int'(bus.BUSY), 0);
    repeat (30) @(negedge CLOCK_50);
    check("abort_no_done", done_cnt, d0);

    // ABORT and START together in IDLE
    @(negedge CLOCK_50);
    bus.ABORT = 1'b1; bus.START = 1'b1; bus.PATTERN = 5'b00001; bus.LENGTH = 3'd1;
    @(negedge CLOCK_50);
    bus.ABORT = 1'b0; bus.START = 1'b0;
    check("abort_start_busy", int'(bus.BUSY), 0);
    check("abort_start_led",  int'(bus.LED_OUT), 0);

    // Back-to-back: START on the cycle after DONE is accepted
    push_letter_a();
    exp_q.push_back(ev_h(4));
`ifdef MORSE_SEQ_LETTER_GAP_EN
    exp_q.push_back(ev_l(12));
`endif
    exp_q.push_back(ev_d());
    start_letter(5'b00010, 3'd2);
    wait_done("b2b_first_done");
    @(negedge CLOCK_50);
    check("b2b_idle_busy", int'(bus.BUSY), 0);
    bus.START = 1'b1; bus.PATTERN = 5'b00000; bus.LENGTH = 3'd1;
    @(negedge CLOCK_50);
    bus.START = 1'b0;
    check("b2b_led_on",  int'(bus.LED_OUT), 1);
    check("b2b_busy_on", int'(bus.BUSY), 1);
    wait_done("b2b_second_done");
    @(negedge CLOCK_50);

    // Reset in the middle of a dash
    d0 = done_cnt;
    start_letter(5'b00111, 3'd3);
    repeat (5) @(negedge CLOCK_50);
    check("pre_reset_led", int'(bus.LED_OUT), 1);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_reset_led",  int'(bus.LED_OUT), 0);
    check("mid_reset_busy", int'(bus.BUSY), 0);
    check("mid_reset_done", int'(bus.DONE), 0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (60) @(negedge CLOCK_50);
    check("post_reset_no_done", done_cnt, d0);
    check("post_reset_busy", int'(bus.BUSY), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
